// File: rtl/disp_scan_if.sv
// Bus between the system and the 4-digit display scan controller.
// The slave side is the controller; the master side is whoever loads digits
// and wires the decoder/anode pins.
interface disp_scan_if;
  // System side
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  point_in;
  logic [3:0]  en_mask;
  logic        blank_en;
  // Decoder / anode side
  logic [3:0]  hex;
  logic        LE;
  logic        point;
  logic [3:0]  AN;
  logic        frame_done;
  logic        pending;

  modport master (
    output load, data_in, point_in, en_mask, blank_en,
    input  hex, LE, point, AN, frame_done, pending
  );

  modport slave (
    input  load, data_in, point_in, en_mask, blank_en,
    output hex, LE, point, AN, frame_done, pending
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed common-anode 7-segment display.
// Time-multiplexes four hex digits onto one shared hex decoder, with a
// double-buffered display copy committed at frame end, leading-zero
// suppression, per-digit masking and a dead gap at the start of every slot.
//
// All outputs are registered but computed from the next (idx, cnt, disp)
// values, so the registered outputs always describe the slot position the
// counters hold in the same cycle.
module disp_scan_ctrl #(
  parameter int DIV  = 8,
  parameter int DEAD = 2
) (
  input  logic        clk,
  input  logic        rst,
  disp_scan_if.slave  bus
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

  typedef enum logic {
    PH_DEAD,
    PH_DRIVE
  } phase_e;

  // Scan position and buffers
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [19:0]   r_shadow;
  logic [19:0]   r_disp;
  logic          r_pending;

  // Registered outputs
  logic [3:0]    r_hex;
  logic          r_le;
  logic          r_point;
  logic [3:0]    r_an;
  logic          r_frame_done;

  // Next-state view used to pre-compute the registered outputs
  logic          w_wrap;
  logic          w_commit;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic [19:0]   w_disp_nxt;
  logic [15:0]   w_upper;
  logic [3:0]    w_pts;
  phase_e        w_phase;
  logic          w_dark;
  logic [3:0]    w_hex_nxt;
  logic          w_le_nxt;
  logic          w_point_nxt;
  logic [3:0]    w_an_nxt;

  // Slot counter / digit index advance and frame-end commit decision
  always_comb begin
    w_wrap     = (r_cnt == CNT_LAST);
    w_commit   = w_wrap && (r_idx == 2'd3);
    w_cnt_nxt  = w_wrap ? '0 : r_cnt + CW'(1);
    w_idx_nxt  = w_wrap ? r_idx + 2'd1 : r_idx;
    w_disp_nxt = (w_commit && r_pending) ? r_shadow : r_disp;
  end

  // Decoder and anode drive for the upcoming slot position
  always_comb begin
    // NOTE: every output of this block gets a default before any branch so a
    // missed path can never hold an old value and infer a latch.
    w_an_nxt    = 4'b1111;
    w_le_nxt    = 1'b1;
    w_point_nxt = 1'b0;
    // Shifting the digit word down leaves this nibble and all higher ones,
    // which is exactly the set the leading-zero test needs.
    w_upper     = w_disp_nxt[15:0] >> {w_idx_nxt, 2'b00};
    w_pts       = w_disp_nxt[19:16];
    w_hex_nxt   = w_upper[3:0];
    w_phase     = (w_cnt_nxt < CNT_DEAD) ? PH_DEAD : PH_DRIVE;
    w_dark      = !bus.en_mask[w_idx_nxt] ||
                  (bus.blank_en && (w_idx_nxt != 2'd0) && (w_upper == 16'h0000));
    if (w_phase == PH_DRIVE && !w_dark) begin
      w_an_nxt    = ~(4'b0001 << w_idx_nxt);
      w_le_nxt    = 1'b0;
      w_point_nxt = w_pts[w_idx_nxt];
    end
  end

  // Scan counters, shadow/display buffers and the pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_shadow  <= 20'h0;
      r_disp    <= 20'h0;
      r_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here let the commit read the old
      // shadow while a same-cycle load writes the new one.
      r_cnt  <= w_cnt_nxt;
      r_idx  <= w_idx_nxt;
      r_disp <= w_disp_nxt;
      if (bus.load) begin
        r_shadow  <= {bus.point_in, bus.data_in};
        r_pending <= 1'b1;
      end else if (w_commit && r_pending) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Output registers, glitch-free toward the decoder and anode drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex        <= 4'h0;
      r_le         <= 1'b1;
      r_point      <= 1'b0;
      r_an         <= 4'b1111;
      r_frame_done <= 1'b0;
    end else begin
      r_hex        <= w_hex_nxt;
      r_le         <= w_le_nxt;
      r_point      <= w_point_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_commit;
    end
  end

  assign bus.hex        = r_hex;
  assign bus.LE         = r_le;
  assign bus.point      = r_point;
  assign bus.AN         = r_an;
  assign bus.frame_done = r_frame_done;
  assign bus.pending    = r_pending;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIV=8, DEAD=2 (frame = 32 cycles).
// t counts rising edges since reset release, so cnt = t%8, idx = (t/8)%4.
module tb_disp_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   t   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  disp_scan_if bus ();

  disp_scan_ctrl #(.DIV(8), .DEAD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (t=%0d): got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // One rising edge, then settle 2 time units past it
  task automatic step();
    @(posedge clk);
    t++;
    #2;
  endtask

  task automatic goto(input int target);
    while (t < target) step();
  endtask

  task automatic slot(input string tag, input logic [3:0] an, input logic le,
                      input logic [3:0] hx, input logic pt);
    check({tag, "_an"},    32'(bus.AN),    32'(an));
    check({tag, "_le"},    32'(bus.LE),    32'(le));
    check({tag, "_hex"},   32'(bus.hex),   32'(hx));
    check({tag, "_point"}, 32'(bus.point), 32'(pt));
  endtask

  // Present a load in the current cycle; it is captured at the next edge
  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.load     = 1'b1;
    bus.data_in  = d;
    bus.point_in = p;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2;
    rst = 1'b0;
    t   = 0;
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.data_in  = 16'h0;
    bus.point_in = 4'h0;
    bus.en_mask  = 4'b1111;
    bus.blank_en = 1'b0;

    // Reset / idle
    #12;
    slot("rst", 4'b1111, 1'b1, 4'h0, 1'b0);
    check("rst_fd",   32'(bus.frame_done), 32'd0);
    check("rst_pend", 32'(bus.pending),    32'd0);
    release_rst();
    check("c0_an", 32'(bus.AN), 32'hF);
    check("c0_fd", 32'(bus.frame_done), 32'd0);
    goto(1);  check("c1_an", 32'(bus.AN), 32'hF);
    goto(2);  slot("c2", 4'b1110, 1'b0, 4'h0, 1'b0);
    goto(7);  slot("c7", 4'b1110, 1'b0, 4'h0, 1'b0);
    goto(8);  slot("c8", 4'b1111, 1'b1, 4'h0, 1'b0);
    goto(10); check("c10_an", 32'(bus.AN), 32'hD);

    // Buffered load at idx 1
    do_load(16'h1234, 4'b0100);
    check("ld_pend", 32'(bus.pending), 32'd1);
    slot("ld_old", 4'b1101, 1'b0, 4'h0, 1'b0);
    goto(31); slot("pre_commit", 4'b0111, 1'b0, 4'h0, 1'b0);
    check("fd_31", 32'(bus.frame_done), 32'd0);
    goto(32); check("fd_32", 32'(bus.frame_done), 32'd1);
    check("pend_32", 32'(bus.pending), 32'd0);
    slot("f1_dead", 4'b1111, 1'b1, 4'h4, 1'b0);
    goto(33); check("fd_33", 32'(bus.frame_done), 32'd0);
    goto(34); slot("f1_s0", 4'b1110, 1'b0, 4'h4, 1'b0);
    goto(42); slot("f1_s1", 4'b1101, 1'b0, 4'h3, 1'b0);
    goto(50); slot("f1_s2", 4'b1011, 1'b0, 4'h2, 1'b1);
    goto(58); slot("f1_s3", 4'b0111, 1'b0, 4'h1, 1'b0);

    // Leading-zero suppression
    goto(60);
    bus.blank_en = 1'b1;
    do_load(16'h0050, 4'b0000);
    goto(66); slot("lz50_s0", 4'b1110, 1'b0, 4'h0, 1'b0);
    goto(74); slot("lz50_s1", 4'b1101, 1'b0, 4'h5, 1'b0);
    goto(82); check("lz50_s2_an", 32'(bus.AN), 32'hF);
    check("lz50_s2_le", 32'(bus.LE), 32'd1);
    goto(90); check("lz50_s3_an", 32'(bus.AN), 32'hF);
    check("lz50_s3_le", 32'(bus.LE), 32'd1);
    goto(91); bus.blank_en = 1'b0;
    goto(92); slot("lz_live_off", 4'b0111, 1'b0, 4'h0, 1'b0);
    bus.blank_en = 1'b1;
    goto(93); check("lz_live_on", 32'(bus.AN), 32'hF);
    goto(94); do_load(16'h0000, 4'b0000);
    goto(98);  slot("lz0_s0", 4'b1110, 1'b0, 4'h0, 1'b0);
    goto(106); check("lz0_s1", 32'(bus.AN), 32'hF);
    goto(114); check("lz0_s2", 32'(bus.AN), 32'hF);
    goto(122); check("lz0_s3", 32'(bus.AN), 32'hF);
    goto(124); do_load(16'h1000, 4'b0000);
    goto(130); slot("lz1k_s0", 4'b1110, 1'b0, 4'h0, 1'b0);
    goto(138); slot("lz1k_s1", 4'b1101, 1'b0, 4'h0, 1'b0);
    goto(146); slot("lz1k_s2", 4'b1011, 1'b0, 4'h0, 1'b0);
    goto(154); slot("lz1k_s3", 4'b0111, 1'b0, 4'h1, 1'b0);

    // Digit masking
    goto(159);
    bus.blank_en = 1'b0;
    bus.en_mask  = 4'b0011;
    goto(162); slot("mk_s0", 4'b1110, 1'b0, 4'h0, 1'b0);
    goto(170); slot("mk_s1", 4'b1101, 1'b0, 4'h0, 1'b0);
    for (int c = 176; c < 192; c++) begin
      goto(c);
      check("mk_hi_an", 32'(bus.AN), 32'hF);
      check("mk_hi_le", 32'(bus.LE), 32'd1);
    end
    bus.en_mask = 4'b1111;

    // Load landing on the commit cycle
    goto(200); do_load(16'h1111, 4'b0000);
    goto(223); do_load(16'h2222, 4'b0000);
    check("lc_fd_224",   32'(bus.frame_done), 32'd1);
    check("lc_pend_224", 32'(bus.pending),    32'd1);
    goto(225); check("lc_fd_225", 32'(bus.frame_done), 32'd0);
    goto(226); slot("lc_A", 4'b1110, 1'b0, 4'h1, 1'b0);
    goto(255); check("lc_fd_255", 32'(bus.frame_done), 32'd0);
    goto(256); check("lc_fd_256", 32'(bus.frame_done), 32'd1);
    check("lc_pend_256", 32'(bus.pending), 32'd0);
    goto(258); slot("lc_B", 4'b1110, 1'b0, 4'h2, 1'b0);

    // Minimum latency: load at idx 3, cnt 6
    goto(286); do_load(16'h3333, 4'b0000);
    check("ml_pend", 32'(bus.pending), 32'd1);
    slot("ml_287", 4'b0111, 1'b0, 4'h2, 1'b0);
    goto(288); check("ml_hex", 32'(bus.hex), 32'h3);
    check("ml_pend_288", 32'(bus.pending), 32'd0);

    // Reset mid-operation with data pending
    goto(300); do_load(16'h4444, 4'b1111);
    goto(306); check("mr_pend_pre", 32'(bus.pending), 32'd1);
    rst = 1'b1;
    #1;
    slot("mr_rst", 4'b1111, 1'b1, 4'h0, 1'b0);
    check("mr_pend", 32'(bus.pending),    32'd0);
    check("mr_fd",   32'(bus.frame_done), 32'd0);
    release_rst();
    check("mr_fd_0", 32'(bus.frame_done), 32'd0);
    goto(1);  check("mr_fd_1", 32'(bus.frame_done), 32'd0);
    goto(2);  slot("mr_s0", 4'b1110, 1'b0, 4'h0, 1'b0);
    goto(10); slot("mr_s1", 4'b1101, 1'b0, 4'h0, 1'b0);
    goto(32); check("mr_fd_32", 32'(bus.frame_done), 32'd1);
    goto(34); slot("mr_f1_s0", 4'b1110, 1'b0, 4'h0, 1'b0);
    check("mr_pend_34", 32'(bus.pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
